// File: rtl/button_edge_detector.sv
// Push-button conditioner: two-flop synchronizer, counter-based debounce, and a
// one-clock strobe on every accepted press (debounced falling edge of the active-low input).
module button_edge_detector #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_value,
    output logic negative_edge_detected
);

    localparam int            COUNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);

    logic               sync1;
    logic               sync2;
    logic               stable;
    logic [COUNT_W-1:0] count;

    logic               stable_next;
    logic [COUNT_W-1:0] count_next;
    logic               pulse_next;

    // Reset value 1 matches the released level, so reset never looks like a press.
    // NOTE: non-blocking assignments keep both flops sampling the same edge; blocking
    // here would collapse the two-stage synchronizer into one stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button_value;
            sync2 <= sync1;
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        stable_next = stable;
        count_next  = '0;
        pulse_next  = 1'b0;
        if (sync2 != stable) begin
            if (count == COUNT_LAST) begin
                stable_next = sync2;
                pulse_next  = ~sync2;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stable                 <= 1'b1;
            count                  <= '0;
            negative_edge_detected <= 1'b0;
        end else begin
            stable                 <= stable_next;
            count                  <= count_next;
            negative_edge_detected <= pulse_next;
        end
    end

endmodule

// File: tb/tb_button_edge_detector.sv
// Randomized and directed stimulus for button_edge_detector, scored cycle by cycle
// against a run-length reference model of the debounce rules.
module tb_button_edge_detector;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic button_value = 1'b1;
    logic negative_edge_detected;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    logic exp_q[$];

    // Reference model: input history seen through a two-edge delay, and the length of
    // the current run of compared values that disagree with the accepted level.
    logic hist[$] = '{1'b1, 1'b1};
    logic m_stable = 1'b1;
    logic m_pulse = 1'b0;
    int   run = 0;

    button_edge_detector #(.DEBOUNCE_CYCLES(D)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .button_value           (button_value),
        .negative_edge_detected (negative_edge_detected)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic cmp;
        if (r) begin
            hist     = '{1'b1, 1'b1};
            run      = 0;
            m_stable = 1'b1;
            m_pulse  = 1'b0;
        end else begin
            hist.push_back(b);
            cmp = hist[hist.size() - 3];
            if (hist.size() > 3) void'(hist.pop_front());
            m_pulse = 1'b0;
            if (cmp == m_stable) begin
                run = 0;
            end else begin
                run++;
                if (run == D) begin
                    m_stable = cmp;
                    run      = 0;
                    m_pulse  = !cmp;
                end
            end
        end
    endtask

    // Drive one clock's worth of inputs and record what the next edge must produce.
    task automatic cycle(input logic b, input logic r);
        @(negedge clock);
        button_value = b;
        reset        = r;
        model_step(b, r);
        exp_q.push_back(m_pulse);
    endtask

    task automatic seg(input logic b, input int n);
        for (int i = 0; i < n; i++) cycle(b, 1'b0);
    endtask

    task automatic settle();
        @(posedge clock);
        #3;
    endtask

    // Monitor: compares the DUT output after every edge that has an expectation queued.
    always begin
        logic e;
        @(posedge clock);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pulse", int'(negative_edge_detected), int'(e));
        end
        if (negative_edge_detected === 1'b1) pulse_cnt++;
    end

    initial begin
        int p0;

        // Reset with button released
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        p0 = pulse_cnt;
        seg(1'b1, 3);
        settle();
        check("reset_pulses", pulse_cnt - p0, 0);
        check("reset_stable", int'(dut.stable), 1);

        // Clean press held 20 cycles, then release
        p0 = pulse_cnt;
        seg(1'b0, 20);
        settle();
        check("clean_press_pulses", pulse_cnt - p0, 1);
        p0 = pulse_cnt;
        seg(1'b1, 10);
        settle();
        check("release_pulses", pulse_cnt - p0, 0);

        // Bounce into a held press
        p0 = pulse_cnt;
        seg(1'b0, 1); seg(1'b1, 1); seg(1'b0, 1); seg(1'b1, 1);
        seg(1'b0, 12);
        seg(1'b1, 10);
        settle();
        check("bounce_pulses", pulse_cnt - p0, 1);

        // 3-cycle low glitches alone
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) begin
            seg(1'b0, 3);
            seg(1'b1, 5);
        end
        settle();
        check("glitch_pulses", pulse_cnt - p0, 0);

        // Press, accepted release, press again
        p0 = pulse_cnt;
        seg(1'b0, 10); seg(1'b1, 10); seg(1'b0, 10); seg(1'b1, 10);
        settle();
        check("repress_pulses", pulse_cnt - p0, 2);

        // Release too short between presses
        p0 = pulse_cnt;
        seg(1'b0, 10); seg(1'b1, 3); seg(1'b0, 10); seg(1'b1, 10);
        settle();
        check("short_release_pulses", pulse_cnt - p0, 1);

        // Reset mid-count, button kept low
        p0 = pulse_cnt;
        seg(1'b0, 5);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        settle();
        check("reset_mid_no_pulse", pulse_cnt - p0, 0);
        seg(1'b0, 10);
        settle();
        check("reset_mid_pulses", pulse_cnt - p0, 1);
        seg(1'b1, 10);

        // Reset at the edge where the pulse would start
        p0 = pulse_cnt;
        seg(1'b0, 5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        seg(1'b1, 10);
        settle();
        check("reset_at_pulse_start", pulse_cnt - p0, 0);

        // Reset at the edge where the pulse would end
        p0 = pulse_cnt;
        seg(1'b0, 6);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        seg(1'b1, 10);
        settle();
        check("reset_at_pulse_end", pulse_cnt - p0, 1);

        // Random runs of levels with occasional reset
        for (int k = 0; k < 300; k++) begin
            logic v;
            int   len;
            bit   r;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            r   = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < len; i++) cycle(v, (r && i == 0) ? 1'b1 : 1'b0);
        end
        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
